pe_bwd: RTL

Backward-pass processing element for the fixed-point systolic ANN array. It is the reverse-direction counterpart of the forward MAC PE: it holds the layer weight and drives it to the forward PE's `b` input. It propagates error partial sums through the array and accumulates the weight gradient over a batch. On command it applies a saturated gradient-descent update to the weight.

---
 rtl/ann_pkg.sv | 28 ++
 rtl/fxp_mul_shift.sv | 18 +
 rtl/pe_bwd.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ann_pkg.sv
// Shared types and helpers for the fixed-point systolic ANN array.
package ann_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int FRAC_BIT_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Clamp a signed value into the range of a signed word of the given width.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                               input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            sat = hi;
        else if (value < lo)
            sat = lo;
        else
            sat = value;
    endfunction

endpackage

// File: rtl/fxp_mul_shift.sv
// Signed full-width fixed-point multiply, rescaled by an arithmetic right shift.
module fxp_mul_shift #(
    parameter int WIDTH    = 16,
    parameter int FRAC_BIT = 10,
    parameter int OUT_W    = 2 * WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [OUT_W-1:0] p
);

    logic signed [2*WIDTH-1:0] prod;

    assign prod = $signed(a) * $signed(b);
    // Callers needing only the low bits of the scaled product narrow it here.
    assign p    = OUT_W'(prod >>> FRAC_BIT);

endmodule

// File: rtl/pe_bwd.sv
// Backward-pass PE: error partial-sum propagation, gradient accumulation and
// saturated gradient-descent weight update.
module pe_bwd
    import ann_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAC_BIT  = FRAC_BIT_DEF,
    parameter int ACC_WIDTH = 32,
    parameter int LR_SHIFT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] delta_in,
    input  logic [WIDTH-1:0] g_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] delta_out,
    output logic [WIDTH-1:0] g_out,
    input  logic             w_load,
    input  logic [WIDTH-1:0] w_in,
    output logic [WIDTH-1:0] w_out,
    input  logic             upd,
    output logic             busy,
    output logic             upd_done
);

    localparam int PW = 2 * WIDTH;

    state_t                      state, state_nxt;
    logic signed [WIDTH-1:0]     w;
    logic signed [WIDTH-1:0]     w_new;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] step;

    logic [WIDTH-1:0]            p_g;
    logic [PW-1:0]               p_a;
    logic signed [ACC_WIDTH-1:0] acc_add;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] step_calc;
    logic signed [WIDTH-1:0]     w_diff;

    // p_g only feeds the wrapping partial-sum adder, so keep its low word.
    fxp_mul_shift #(.WIDTH(WIDTH), .FRAC_BIT(FRAC_BIT), .OUT_W(WIDTH)) u_mul_g (
        .a (w),
        .b (delta_in),
        .p (p_g)
    );

    fxp_mul_shift #(.WIDTH(WIDTH), .FRAC_BIT(FRAC_BIT), .OUT_W(PW)) u_mul_a (
        .a (a_in),
        .b (delta_in),
        .p (p_a)
    );

    assign acc_add   = ACC_WIDTH'(sat(64'(acc) + 64'($signed(p_a)), ACC_WIDTH));
    assign acc_next  = en ? acc_add : acc;
    assign step_calc = acc_next >>> LR_SHIFT;
    assign w_diff    = WIDTH'(sat(64'(w) - 64'(step), WIDTH));

    assign w_out    = w;
    assign busy     = (state != IDLE);
    assign upd_done = (state == WRITE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (upd) state_nxt = CALC;
            CALC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A weight load aborts any update in flight.
        if (w_load)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out     <= '0;
            delta_out <= '0;
            g_out     <= '0;
        end else if (en) begin
            a_out     <= a_in;
            delta_out <= delta_in;
            g_out     <= g_in + p_g;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w     <= '0;
            w_new <= '0;
            acc   <= '0;
            step  <= '0;
        end else if (w_load) begin
            w   <= w_in;
            acc <= '0;
        end else begin
            acc <= acc_next;
            unique case (state)
                IDLE: begin
                    // Step folds in this cycle's product; acc restarts empty.
                    if (upd) begin
                        step <= step_calc;
                        acc  <= '0;
                    end
                end
                CALC:    w_new <= w_diff;
                WRITE:   w     <= w_new;
                default: ;
            endcase
        end
    end

endmodule
